decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Registered, parametrised RV32/RV64 instruction decode stage sitting between fetch and execute.
- Accepts instruction words over a valid/ready handshake and splits them into fields and a sign-extended immediate.
- Classifies the instruction format and flags illegal encodings, including funct-level checks and an optional M extension.
- Buffers through a 2-entry skid buffer so that back-pressure never drops or duplicates an instruction, and keeps a saturating illegal-instruction counter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Sets immediate/PC width and the RV64-only legality rules.
- M_EXT, 1, 1 = funct7 0000001 on OP (and OP-32 when XLEN=64) is legal.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- flush  in  1  discard all buffered instructions
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC of decoded entry
- out_opcode  out  7  instr[6:0]
- out_rd  out  5  instr[11:7]
- out_funct3  out  3  instr[14:12]
- out_rs1  out  5  instr[19:15]
- out_rs2  out  5  instr[24:20]
- out_funct7  out  7  instr[31:25]
- out_imm  out  XLEN  sign-extended immediate
- out_fmt  out  3  format: R=0, I=1, S=2, B=3, U=4, J=5, NONE=7
- out_illegal  out  1  illegal encoding
- cnt_clr  in  1  clear illegal counter
- illegal_cnt  out  CNT_W  saturating count of illegal instructions delivered

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values:
  - out_valid=0, in_ready=1, illegal_cnt=0.
  - All payload registers 0; out_fmt=7.
  - Reset mid-stream discards both buffer entries.
- Decode: combinational on in_instr, registered on acceptance. Latency 1 cycle, from the in_valid&in_ready edge to out_valid.
- Skid buffer:
  - Entries are MAIN (drives outputs) and SKID.
  - in_ready = !skid_full; it is a registered signal.
  - On accept: if MAIN is empty, or MAIN is being consumed this cycle and SKID is empty, load MAIN. Otherwise load SKID.
  - On out_valid&out_ready with SKID full: SKID moves to MAIN.
  - Order is strictly FIFO; full throughput is 1 instruction/cycle when out_ready=1.
- Flush:
  - flush clears both entries next cycle: out_valid=0, in_ready=1.
  - flush has priority; an instruction offered in the flush cycle is dropped.
  - A handshake completing at the output in the flush cycle still counts.
- Immediates, all sign-extended from instr[31]:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and NONE: 0.
- Format map:
  - LUI/AUIPC → U.
  - JAL → J.
  - JALR, LOAD, OP-IMM, OP-IMM-32, MISC-MEM, SYSTEM → I.
  - STORE → S.
  - BRANCH → B.
  - OP, OP-32 → R.
  - Any other opcode → NONE.
- Illegal when any of:
  - instr[1:0]≠11.
  - Opcode not in {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011, 0001111, 1110011}, plus {0011011, 0111011} when XLEN=64.
  - JALR funct3≠000.
  - BRANCH funct3 ∈ {010, 011}.
  - LOAD funct3 = 111, or funct3 ∈ {011, 110} when XLEN=32.
  - STORE funct3 ≥ 100, or funct3 = 011 when XLEN=32.
  - OP-IMM shift (funct3 001/101) with bad upper bits:
    - XLEN=32: funct7 must be 0000000, or 0100000 only for funct3=101.
    - XLEN=64: instr[31:26] is checked the same way; instr[25] is shamt[5].
  - OP/OP-32 funct7 not in {0000000, 0100000 (only for funct3 000/101), 0000001 (only if M_EXT)}.
  - OP-32 with M_EXT and funct3 ∈ {001, 010, 011}.
- Counter:
  - Increments on out_valid & out_ready & out_illegal.
  - Saturates at 2^CNT_W-1.
  - cnt_clr takes priority over an increment in the same cycle (result 0).

Decomposition:
- Shared package decode_pkg holds:
  - Opcode constants (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_OP_IMM_32, OPC_OP_32, OPC_MISC_MEM, OPC_SYSTEM).
  - The fmt encoding constants.
  - A decoded-entry struct: pc, fields, imm, fmt, illegal.
- Sub-module decode_comb (purely combinational field/immediate/legality logic, same parameters) is instantiated once ahead of the skid buffer.

Test Plan:
- Basic decode: 0xFFF10093 (addi x1,x2,-1), pc 0x100, out_ready=1 → next cycle out_valid=1, opcode=0x13, rd=1, rs1=2, imm=0xFFFFFFFF, fmt=1, illegal=0, out_pc=0x100.
- Branch immediate: 0xFE000EE3 (beq -4) → fmt=3, imm=0xFFFFFFFC, illegal=0.
- Back-pressure: out_ready=0, two back-to-back instructions A, B → in_ready=0 after B; third is held upstream; raising out_ready delivers A then B in consecutive cycles with no loss.
- M extension: 0x02208033 (mul) → illegal=0 when M_EXT=1, illegal=1 when M_EXT=0. Separately, 0x00000000 → illegal=1, fmt=7.
- Counter: CNT_W=4, 20 illegal words accepted at the output → illegal_cnt=15. cnt_clr asserted together with an illegal handshake → 0.
- Flush and reset: flush with both entries full → next cycle out_valid=0, in_ready=1, and the word offered during flush never appears. rst mid-stream → all outputs at reset values next cycle.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcode/format constants and the decoded-entry record carried through the
// decode stage. Widths are sized for RV64 so one record type serves both XLEN settings.
package decode_pkg;

  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [2:0]          funct3;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [6:0]          funct7;
    logic [XLEN_MAX-1:0] imm;
    logic [2:0]          fmt;
    logic                illegal;
  } dec_entry_t;

  localparam dec_entry_t ENTRY_RESET = '{
    pc: '0, opcode: '0, rd: '0, funct3: '0, rs1: '0, rs2: '0,
    funct7: '0, imm: '0, fmt: FMT_NONE, illegal: 1'b0
  };

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle. The decode stage sits on
// the slave side; whoever feeds instructions and consumes decoded entries is the master.
interface decode_stage_if #(parameter int XLEN = 32);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3,
           out_rs1, out_rs2, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational field split, immediate generation, format classification and
// legality check for one RV32/RV64 instruction word.
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1
) (
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  output dec_entry_t      entry
);

  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [2:0]  fmt;
  logic [31:0] imm32;
  logic        illegal;
  logic        shift_hi_zero;
  logic        shift_hi_sra;
  logic        shift_ok;
  logic        op_f7_ok;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  always_comb begin
    fmt = FMT_NONE;
    case (opc)
      OPC_LUI, OPC_AUIPC:                        fmt = FMT_U;
      OPC_JAL:                                   fmt = FMT_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_OP_IMM_32, OPC_MISC_MEM, OPC_SYSTEM:   fmt = FMT_I;
      OPC_STORE:                                 fmt = FMT_S;
      OPC_BRANCH:                                fmt = FMT_B;
      OPC_OP, OPC_OP_32:                         fmt = FMT_R;
      default:                                   fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // On RV64 instr[25] is shamt[5], so only the top six bits qualify the shift.
  assign shift_hi_zero = (XLEN == 64) ? (instr[31:26] == 6'b000000) : (f7 == 7'b0000000);
  assign shift_hi_sra  = (XLEN == 64) ? (instr[31:26] == 6'b010000) : (f7 == 7'b0100000);
  assign shift_ok      = shift_hi_zero || (shift_hi_sra && (f3 == 3'b101));

  assign op_f7_ok = (f7 == 7'b0000000) ||
                    ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                    (M_EXT && (f7 == 7'b0000001));

  always_comb begin
    illegal = (instr[1:0] != 2'b11);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_MISC_MEM, OPC_SYSTEM: ;
      OPC_JALR:      if (f3 != 3'b000) illegal = 1'b1;
      OPC_BRANCH:    if ((f3 == 3'b010) || (f3 == 3'b011)) illegal = 1'b1;
      OPC_LOAD:      if ((f3 == 3'b111) ||
                         ((XLEN == 32) && ((f3 == 3'b011) || (f3 == 3'b110)))) illegal = 1'b1;
      OPC_STORE:     if (f3[2] || ((XLEN == 32) && (f3 == 3'b011))) illegal = 1'b1;
      OPC_OP_IMM:    if (((f3 == 3'b001) || (f3 == 3'b101)) && !shift_ok) illegal = 1'b1;
      OPC_OP_IMM_32: if (XLEN == 32) illegal = 1'b1;
      OPC_OP:        if (!op_f7_ok) illegal = 1'b1;
      // RV64M has no MULHW/MULHSUW/MULHUW: reject M-encoded OP-32 with funct3 001..011.
      OPC_OP_32:     if ((XLEN == 32) || !op_f7_ok ||
                         (M_EXT && (f7 == 7'b0000001) &&
                          ((f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011)))) illegal = 1'b1;
      default:       illegal = 1'b1;
    endcase
  end

  always_comb begin
    entry         = ENTRY_RESET;
    entry.pc      = XLEN_MAX'(pc);
    entry.opcode  = opc;
    entry.rd      = instr[11:7];
    entry.funct3  = f3;
    entry.rs1     = instr[19:15];
    entry.rs2     = instr[24:20];
    entry.funct7  = f7;
    entry.imm     = {{32{imm32[31]}}, imm32};
    entry.fmt     = fmt;
    entry.illegal = illegal;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decode_comb ahead of a 2-entry skid buffer (MAIN drives the
// outputs, SKID absorbs one extra word under back-pressure) plus a saturating illegal counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter bit M_EXT = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  decode_stage_if.slave     bus,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  dec_entry_t dec;
  dec_entry_t main_q;
  dec_entry_t skid_q;
  logic       main_v;
  logic       skid_v;
  logic       in_ready_q;
  logic       accept;
  logic       consume;

  decode_comb #(.XLEN(XLEN), .M_EXT(M_EXT)) u_comb (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .entry (dec)
  );

  assign accept  = bus.in_valid && in_ready_q && !flush;
  assign consume = main_v && bus.out_ready;

  // in_ready_q always equals !skid_v, so no accept can coincide with a SKID->MAIN move.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
      main_q     <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
    end else if (flush) begin
      main_v     <= 1'b0;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (consume && skid_v) begin
      main_q     <= skid_q;
      skid_v     <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (accept) begin
      if (!main_v || consume) begin
        main_q <= dec;
        main_v <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_v     <= 1'b1;
        in_ready_q <= 1'b0;
      end
    end else if (consume) begin
      main_v <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      illegal_cnt <= '0;
    end else if (consume && main_q.illegal && (illegal_cnt != CNT_MAX)) begin
      illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_v;
  assign bus.out_pc      = main_q.pc[XLEN-1:0];
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm[XLEN-1:0];
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;

  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps plus random traffic, checked against a
// FIFO-of-words model and an arithmetic reference decoder for RV32.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush, cnt_clr;
  logic [3:0] illegal_cnt;
  logic       flush0, cnt_clr0;
  logic [15:0] illegal_cnt0;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } ref_t;

  item_t q[$];
  int    mcnt;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) u_if  ();
  decode_stage_if #(.XLEN(32)) u_if0 ();

  decode_stage #(.XLEN(32), .M_EXT(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .bus(u_if.slave), .flush(flush), .cnt_clr(cnt_clr),
    .illegal_cnt(illegal_cnt)
  );

  decode_stage #(.XLEN(32), .M_EXT(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave), .flush(flush0), .cnt_clr(cnt_clr0),
    .illegal_cnt(illegal_cnt0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ref_t ref_decode(input logic [31:0] w, input bit m);
    ref_t r;
    logic [31:0] sgn;
    int op, f3, f7;
    op  = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    sgn = 32'($signed(w) >>> 31);
    case (op)
      'h37, 'h17:                          r.fmt = 3'd4;
      'h6F:                                r.fmt = 3'd5;
      'h67, 'h03, 'h13, 'h1B, 'h0F, 'h73:  r.fmt = 3'd1;
      'h23:                                r.fmt = 3'd2;
      'h63:                                r.fmt = 3'd3;
      'h33, 'h3B:                          r.fmt = 3'd0;
      default:                             r.fmt = 3'd7;
    endcase
    case (r.fmt)
      3'd1: r.imm = 32'($signed(w) >>> 20);
      3'd2: r.imm = (32'($signed(w) >>> 25) << 5) | 32'(w[11:7]);
      3'd3: r.imm = (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      3'd4: r.imm = w & 32'hFFFF_F000;
      3'd5: r.imm = (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
      default: r.imm = 32'd0;
    endcase
    case (op)
      'h37, 'h17, 'h6F, 'h0F, 'h73: r.illegal = 1'b0;
      'h67: r.illegal = (f3 != 0);
      'h63: r.illegal = (f3 == 2) || (f3 == 3);
      'h03: r.illegal = (f3 == 7) || (f3 == 3) || (f3 == 6);
      'h23: r.illegal = (f3 >= 3);
      'h13: begin
        if (f3 == 1)      r.illegal = (f7 != 0);
        else if (f3 == 5) r.illegal = !((f7 == 0) || (f7 == 32));
        else              r.illegal = 1'b0;
      end
      'h33: r.illegal = !((f7 == 0) || ((f7 == 32) && ((f3 == 0) || (f3 == 5))) || ((f7 == 1) && m));
      default: r.illegal = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [6:0] pick_op(input int sel);
    case (sel)
      0: return 7'h37;  1: return 7'h17;  2: return 7'h6F;  3: return 7'h67;
      4: return 7'h63;  5: return 7'h03;  6: return 7'h23;  7: return 7'h13;
      8: return 7'h33;  9: return 7'h0F; 10: return 7'h73; 11: return 7'h1B;
      12: return 7'h3B;
      default: return 7'($urandom);
    endcase
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = r[31:25];
    endcase
    return {f7, r[24:7], pick_op($urandom_range(0, 15))};
  endfunction

  task automatic check_outputs();
    ref_t e;
    chk("out_valid", 64'(u_if.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(u_if.in_ready), 64'(q.size() < 2));
    chk("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
    if (q.size() != 0) begin
      e = ref_decode(q[0].instr, 1'b1);
      chk("out_pc", 64'(u_if.out_pc), 64'(q[0].pc));
      chk("out_opcode", 64'(u_if.out_opcode), 64'(q[0].instr[6:0]));
      chk("out_rd", 64'(u_if.out_rd), 64'(q[0].instr[11:7]));
      chk("out_funct3", 64'(u_if.out_funct3), 64'(q[0].instr[14:12]));
      chk("out_rs1", 64'(u_if.out_rs1), 64'(q[0].instr[19:15]));
      chk("out_rs2", 64'(u_if.out_rs2), 64'(q[0].instr[24:20]));
      chk("out_funct7", 64'(u_if.out_funct7), 64'(q[0].instr[31:25]));
      chk("out_imm", 64'(u_if.out_imm), 64'(e.imm));
      chk("out_fmt", 64'(u_if.out_fmt), 64'(e.fmt));
      chk("out_illegal", 64'(u_if.out_illegal), 64'(e.illegal));
    end
  endtask

  // Check at the falling edge, then advance the model by what the next rising edge does.
  task automatic tick();
    bit out_hs, in_hs;
    @(negedge clk);
    check_outputs();
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else begin
      out_hs = (q.size() != 0) && u_if.out_ready;
      in_hs  = u_if.in_valid && (q.size() < 2) && !flush;
      if (cnt_clr) mcnt = 0;
      else if (out_hs && ref_decode(q[0].instr, 1'b1).illegal && (mcnt < 15)) mcnt++;
      if (out_hs) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_hs) q.push_back('{instr: u_if.in_instr, pc: u_if.in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] w, input logic [31:0] pc);
    u_if.in_valid = 1'b1;
    u_if.in_instr = w;
    u_if.in_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    flush0 = 1'b0; cnt_clr0 = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_instr = '0; u_if.in_pc = '0; u_if.out_ready = 1'b1;
    u_if0.in_valid = 1'b0; u_if0.in_instr = '0; u_if0.in_pc = '0; u_if0.out_ready = 1'b1;
    mcnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst in_ready", 64'(u_if.in_ready), 64'd1);
    chk("rst cnt", 64'(illegal_cnt), 64'd0);
    chk("rst out_fmt", 64'(u_if.out_fmt), 64'd7);
    chk("rst out_pc", 64'(u_if.out_pc), 64'd0);
    chk("rst out_imm", 64'(u_if.out_imm), 64'd0);

    offer(32'hFFF1_0093, 32'h100);
    tick();
    u_if.in_valid = 1'b0;
    chk("addi valid", 64'(u_if.out_valid), 64'd1);
    chk("addi opcode", 64'(u_if.out_opcode), 64'h13);
    chk("addi rd", 64'(u_if.out_rd), 64'd1);
    chk("addi rs1", 64'(u_if.out_rs1), 64'd2);
    chk("addi imm", 64'(u_if.out_imm), 64'hFFFF_FFFF);
    chk("addi fmt", 64'(u_if.out_fmt), 64'd1);
    chk("addi illegal", 64'(u_if.out_illegal), 64'd0);
    chk("addi pc", 64'(u_if.out_pc), 64'h100);
    tick();

    offer(32'hFE00_0EE3, 32'h104);
    tick();
    u_if.in_valid = 1'b0;
    chk("beq fmt", 64'(u_if.out_fmt), 64'd3);
    chk("beq imm", 64'(u_if.out_imm), 64'hFFFF_FFFC);
    chk("beq illegal", 64'(u_if.out_illegal), 64'd0);
    tick();

    // Back-pressure: A and B fill both entries, C waits upstream.
    u_if.out_ready = 1'b0;
    offer(32'h0000_0013, 32'h200); tick();
    offer(32'h0010_0093, 32'h204); tick();
    chk("bp in_ready", 64'(u_if.in_ready), 64'd0);
    offer(32'h0020_0113, 32'h208); tick(); tick();
    u_if.in_valid  = 1'b0;
    u_if.out_ready = 1'b1;
    chk("bp first", 64'(u_if.out_pc), 64'h200);
    tick();
    chk("bp second", 64'(u_if.out_pc), 64'h204);
    tick();
    chk("bp drained", 64'(u_if.out_valid), 64'd0);

    offer(32'h0220_8033, 32'h300);
    u_if0.in_valid = 1'b1; u_if0.in_instr = 32'h0220_8033; u_if0.in_pc = 32'h300;
    tick();
    u_if.in_valid = 1'b0; u_if0.in_valid = 1'b0;
    chk("mul m1 illegal", 64'(u_if.out_illegal), 64'd0);
    chk("mul m0 valid", 64'(u_if0.out_valid), 64'd1);
    chk("mul m0 illegal", 64'(u_if0.out_illegal), 64'd1);

    offer(32'h0000_0000, 32'h304);
    tick();
    u_if.in_valid = 1'b0;
    chk("zero illegal", 64'(u_if.out_illegal), 64'd1);
    chk("zero fmt", 64'(u_if.out_fmt), 64'd7);
    tick();

    for (int i = 0; i < 20; i++) begin
      offer(32'h0000_0000, 32'h400 + 32'(i * 4));
      tick();
    end
    u_if.in_valid = 1'b0;
    tick(); tick();
    chk("cnt saturate", 64'(illegal_cnt), 64'd15);

    offer(32'hFFFF_FFFF, 32'h500);
    tick();
    u_if.in_valid = 1'b0;
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("cnt clr prio", 64'(illegal_cnt), 64'd0);

    u_if.out_ready = 1'b0;
    offer(32'h0000_0013, 32'h600); tick();
    offer(32'h0000_0013, 32'h604); tick();
    offer(32'h0000_0513, 32'h608);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    u_if.in_valid = 1'b0;
    chk("flush valid", 64'(u_if.out_valid), 64'd0);
    chk("flush ready", 64'(u_if.in_ready), 64'd1);
    u_if.out_ready = 1'b1;
    tick(); tick();

    u_if.out_ready = 1'b1;
    offer(32'h0000_0000, 32'h700); tick(); tick();
    u_if.out_ready = 1'b0;
    offer(32'h0000_0013, 32'h704); tick();
    offer(32'h0000_0013, 32'h708); tick();
    u_if.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2 valid", 64'(u_if.out_valid), 64'd0);
    chk("rst2 ready", 64'(u_if.in_ready), 64'd1);
    chk("rst2 cnt", 64'(illegal_cnt), 64'd0);
    chk("rst2 fmt", 64'(u_if.out_fmt), 64'd7);
    chk("rst2 pc", 64'(u_if.out_pc), 64'd0);

    for (int i = 0; i < 800; i++) begin
      u_if.in_valid  = ($urandom_range(0, 3) != 0);
      u_if.in_instr  = gen_instr();
      u_if.in_pc     = $urandom & 32'hFFFF_FFFC;
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      flush          = ($urandom_range(0, 39) == 0);
      cnt_clr        = ($urandom_range(0, 59) == 0);
      tick();
    end
    u_if.in_valid = 1'b0; u_if.out_ready = 1'b1; flush = 1'b0; cnt_clr = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
